// File: rtl/ad_uart_report.sv
// Multi-channel ASCII voltage report: snapshots BCD readings, formats "ADn:sX.YYYV  " per channel
// plus LF/CR, and serialises each character on an 8N1 UART (CLK_DIV cycles per bit).
module ad_uart_report #(
    parameter int CH_NUM    = 8,
    parameter int DIGITS    = 5,
    parameter int CLK_DIV   = 434,
    parameter int FRAME_GAP = 65535,
    parameter int CONT_MODE = 1
) (
    input  logic                       clk50,
    input  logic                       reset,
    input  logic [CH_NUM*DIGITS*4-1:0] ch_dec,
    input  logic [CH_NUM*8-1:0]        ch_sig,
    input  logic                       trig,
    output logic                       tx,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       bad_digit
);
    localparam int CPC = DIGITS + 9;
    localparam int PW  = $clog2(CPC);
    localparam int CW  = $clog2(CH_NUM + 1);
    localparam int BW  = $clog2(CLK_DIV);
    localparam int GW  = $clog2(FRAME_GAP + 1);
    localparam int DW  = CH_NUM * DIGITS * 4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHAR, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [BW-1:0]       baud_q, baud_d;
    logic [3:0]          bit_q, bit_d;
    logic [8:0]          sh_q, sh_d;
    logic                tx_q, tx_d;
    logic                bad_q, bad_d;
    logic [DW-1:0]       snap_dec_q, snap_dec_d;
    logic [CH_NUM*8-1:0] snap_sig_q, snap_sig_d;

    logic          trailer, last_chr, is_dig;
    logic [PW-1:0] dig_idx;
    logic [3:0]    nib;
    logic [7:0]    sig_chr, chr;

    // Character mux: channel index selects the snapshot slice, position selects the field.
    always_comb begin
        trailer  = (ch_q == CW'(CH_NUM));
        last_chr = trailer && (pos_q == PW'(1));
        is_dig   = (pos_q == PW'(5)) || ((pos_q >= PW'(7)) && (pos_q <= PW'(DIGITS + 5)));
        dig_idx  = (pos_q == PW'(5)) ? '0 : pos_q - PW'(6);
        nib      = 4'd0;
        sig_chr  = 8'd0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_q == CW'(c)) begin
                sig_chr = snap_sig_q[c*8 +: 8];
                for (int d = 0; d < DIGITS; d++) begin
                    if (dig_idx == PW'(d)) nib = snap_dec_q[c*DIGITS*4 + (DIGITS-1-d)*4 +: 4];
                end
            end
        end
        chr = 8'd32;
        if (trailer)                       chr = (pos_q == '0) ? 8'd10 : 8'd13;
        else if (pos_q == PW'(0))          chr = 8'd65;
        else if (pos_q == PW'(1))          chr = 8'd68;
        else if (pos_q == PW'(2))          chr = 8'd49 + 8'(ch_q);
        else if (pos_q == PW'(3))          chr = 8'd58;
        else if (pos_q == PW'(4))          chr = sig_chr;
        else if (is_dig)                   chr = (nib > 4'd9) ? 8'd63 : {4'd3, nib};
        else if (pos_q == PW'(6))          chr = 8'd46;
        else if (pos_q == PW'(DIGITS + 6)) chr = 8'd86;
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        pos_d      = pos_q;
        ch_d       = ch_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        bad_d      = bad_q;
        snap_dec_d = snap_dec_q;
        snap_sig_d = snap_sig_q;
        case (state_q)
            S_IDLE: begin
                if (CONT_MODE != 0) begin
                    if (gap_q == GW'(FRAME_GAP - 1)) begin
                        gap_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else if (trig) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                snap_dec_d = ch_dec;
                snap_sig_d = ch_sig;
                state_d    = S_CHAR;
            end
            S_CHAR: begin
                sh_d    = {1'b1, chr};
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = 4'd0;
                state_d = S_SHIFT;
                if (is_dig && !trailer && (nib > 4'd9)) bad_d = 1'b1;
            end
            S_SHIFT: begin
                if (baud_q == BW'(CLK_DIV - 1)) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        tx_d = 1'b1;
                        if (last_chr) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CHAR;
                            if (pos_q == PW'(CPC - 1)) begin
                                pos_d = '0;
                                ch_d  = ch_q + CW'(1);
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end
                    end else begin
                        // sh_q[8] is the stop bit; it reaches bit 0 after eight shifts.
                        bit_d = bit_q + 4'd1;
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[8:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DONE: begin
                pos_d   = '0;
                ch_d    = '0;
                gap_d   = '0;
                baud_d  = '0;
                bit_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            pos_q      <= '0;
            ch_q       <= '0;
            baud_q     <= '0;
            bit_q      <= 4'd0;
            sh_q       <= '1;
            tx_q       <= 1'b1;
            bad_q      <= 1'b0;
            snap_dec_q <= '0;
            snap_sig_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pos_q      <= pos_d;
            ch_q       <= ch_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            bad_q      <= bad_d;
            snap_dec_q <= snap_dec_d;
            snap_sig_q <= snap_sig_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_CHAR) || (state_q == S_SHIFT);
    assign frame_done = (state_q == S_DONE);
    assign bad_digit  = bad_q;
endmodule
